// File: rtl/game_pkt_pkg.sv
// Shared frame layout, field widths and decoder state encoding for the
// opponent-position link; the transmit block builds frames from the same constants.
package game_pkt_pkg;

    localparam logic [15:0] ETHERTYPE_DEF = 16'h88B5;
    localparam logic [7:0]  MAGIC_DEF     = 8'hA5;

    localparam int IDX_W   = 5;
    localparam int COORD_W = 11;
    localparam int DIR_W   = 9;
    localparam int STAT_W  = 8;

    localparam logic [DIR_W-1:0] DIR_MAX_DEF = 9'd359;

    localparam logic [IDX_W-1:0] OFF_TYPE_HI = 5'd12;
    localparam logic [IDX_W-1:0] OFF_TYPE_LO = 5'd13;
    localparam logic [IDX_W-1:0] OFF_MAGIC   = 5'd14;
    localparam logic [IDX_W-1:0] OFF_X_HI    = 5'd15;
    localparam logic [IDX_W-1:0] OFF_X_LO    = 5'd16;
    localparam logic [IDX_W-1:0] OFF_Y_HI    = 5'd17;
    localparam logic [IDX_W-1:0] OFF_Y_LO    = 5'd18;
    localparam logic [IDX_W-1:0] OFF_DIR_HI  = 5'd19;
    localparam logic [IDX_W-1:0] OFF_DIR_LO  = 5'd20;
    localparam logic [IDX_W-1:0] OFF_STAT    = 5'd21;
    localparam logic [IDX_W-1:0] OFF_CSUM    = 5'd22;
    localparam logic [IDX_W-1:0] IDX_MAX     = 5'd31;

    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Coordinates travel as two bytes; only the low COORD_W bits are meaningful.
    function automatic logic [COORD_W-1:0] join_coord(input logic [COORD_W-9:0] hi,
                                                      input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/game_pkt_decoder.sv
// Decodes opponent state frames from the receive byte stream and publishes
// each validated frame atomically on opp_*, counting rejected game frames.
module game_pkt_decoder
    import game_pkt_pkg::*;
#(
    parameter logic [15:0]      ETHERTYPE = ETHERTYPE_DEF,
    parameter logic [7:0]       MAGIC     = MAGIC_DEF,
    parameter logic [DIR_W-1:0] DIR_MAX   = DIR_MAX_DEF
) (
    input  logic               eth_clk,
    input  logic               eth_rst,
    input  logic               axiiv,
    input  logic [7:0]         axiid,
    input  logic               axiilast,
    input  logic               crc_ok,
    output logic [COORD_W-1:0] opp_x,
    output logic [COORD_W-1:0] opp_y,
    output logic [DIR_W-1:0]   opp_dir,
    output logic [STAT_W-1:0]  opp_stat,
    output logic               update,
    output logic [7:0]         drop_count
);

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic               type_ok;
    logic               pass_ok;

    logic [7:0]         type_hi;
    logic [7:0]         xor_acc;
    logic [COORD_W-9:0] field_hi;
    logic               magic_ok;
    logic [COORD_W-1:0] x_sh;
    logic [COORD_W-1:0] y_sh;
    logic [DIR_W-1:0]   dir_sh;
    logic [STAT_W-1:0]  stat_sh;

    logic type_match;
    logic at_chk;
    logic frame_ok;
    logic type_seen;
    logic frame_end;
    logic accept;
    logic reject;

    // A frame ending exactly on the checksum byte is judged from the live byte.
    assign type_match = ({type_hi, axiid} == ETHERTYPE);
    assign at_chk     = (state == ST_PAYLOAD) && (idx == OFF_CSUM);
    assign frame_ok   = at_chk ? (magic_ok && (xor_acc == axiid) && (dir_sh <= DIR_MAX))
                               : pass_ok;
    assign type_seen  = ((state == ST_HDR) && (idx == OFF_TYPE_LO) && type_match) ||
                        ((state != ST_HDR) && type_ok);
    assign frame_end  = axiiv && axiilast;
    assign accept     = frame_end && frame_ok && crc_ok;
    assign reject     = frame_end && type_seen && !(frame_ok && crc_ok);

    always_ff @(posedge eth_clk) begin
        update <= 1'b0;
        if (eth_rst) begin
            state      <= ST_HDR;
            idx        <= '0;
            type_ok    <= 1'b0;
            pass_ok    <= 1'b0;
            opp_x      <= '0;
            opp_y      <= '0;
            opp_dir    <= '0;
            opp_stat   <= '0;
            drop_count <= '0;
        end else if (axiiv) begin
            if (axiilast) begin
                idx     <= '0;
                state   <= ST_HDR;
                type_ok <= 1'b0;
                pass_ok <= 1'b0;
                if (accept) begin
                    opp_x    <= x_sh;
                    opp_y    <= y_sh;
                    opp_dir  <= dir_sh;
                    opp_stat <= stat_sh;
                    update   <= 1'b1;
                end
                if (reject && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else begin
                if (idx != IDX_MAX) begin
                    idx <= idx + 5'd1;
                end
                case (state)
                    ST_HDR: begin
                        if (idx == OFF_TYPE_LO) begin
                            state   <= type_match ? ST_PAYLOAD : ST_DRAIN;
                            type_ok <= type_match;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (at_chk) begin
                            state   <= ST_DRAIN;
                            pass_ok <= frame_ok;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shadow capture; opp_* only ever loads a complete, checked set of these.
    always_ff @(posedge eth_clk) begin
        if (axiiv) begin
            if ((state == ST_HDR) && (idx == OFF_TYPE_HI)) begin
                type_hi <= axiid;
            end
            if (state == ST_PAYLOAD) begin
                if (idx == OFF_MAGIC) begin
                    xor_acc  <= axiid;
                    magic_ok <= (axiid == MAGIC);
                end else if (idx < OFF_CSUM) begin
                    xor_acc <= xor_acc ^ axiid;
                end
                case (idx)
                    OFF_X_HI, OFF_Y_HI, OFF_DIR_HI: field_hi <= axiid[COORD_W-9:0];
                    OFF_X_LO:   x_sh    <= join_coord(field_hi, axiid);
                    OFF_Y_LO:   y_sh    <= join_coord(field_hi, axiid);
                    OFF_DIR_LO: dir_sh  <= {field_hi[0], axiid};
                    OFF_STAT:   stat_sh <= axiid;
                    default: ;
                endcase
            end
        end
    end

endmodule
